// File: rtl/bgpv_tot_counter_if.sv
// Record channel from the ToT digitizer to the pixel-region buffer.
//
// Handshake: the master holds HitValid/HitTot/HitBcid stable while
// HitValid=1. A record transfers on every rising Clk edge where
// HitValid & HitReady are both 1. HitReady may be asserted with or without
// HitValid, and the master never waits for HitReady before raising HitValid.
interface bgpv_tot_counter_if #(
  parameter int TOT_WIDTH  = 4,
  parameter int BCID_WIDTH = 8
);
  logic                  HitValid;
  logic [TOT_WIDTH-1:0]  HitTot;
  logic [BCID_WIDTH-1:0] HitBcid;
  logic                  HitReady;

  modport master (
    output HitValid,
    output HitTot,
    output HitBcid,
    input  HitReady
  );

  modport slave (
    input  HitValid,
    input  HitTot,
    input  HitBcid,
    output HitReady
  );
endinterface

// File: rtl/bgpv_tot_counter.sv
// Per-pixel ToT digitizer: synchronizes the gated FE hit, measures its
// length in bunch-crossing cycles, tags it with the leading-edge BCID and
// offers one record at a time to the region buffer. Records that find the
// output register occupied and not draining are dropped and counted.
module bgpv_tot_counter #(
  parameter int TOT_WIDTH   = 4,
  parameter int MAX_TOT     = 14,
  parameter int BCID_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  HitIn,
  input  logic [BCID_WIDTH-1:0] BcidIn,
  input  logic                  Enable,
  output logic                  Busy,
  output logic [7:0]            OvfCnt,
  input  logic                  ClearOvf,
  bgpv_tot_counter_if.master    rec_if,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT    = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_e;

  localparam logic [TOT_WIDTH-1:0] MAX_TOT_C = TOT_WIDTH'(MAX_TOT);
  localparam logic [TOT_WIDTH-1:0] ONE_C     = TOT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_dly_q;
  logic                   s;
  logic                   rise;

  state_e                 state_q, state_d;
  logic [TOT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BCID_WIDTH-1:0]  bcid_q, bcid_d;
  logic                   emit;

  logic                   valid_q;
  logic [TOT_WIDTH-1:0]   tot_q;
  logic [BCID_WIDTH-1:0]  rec_bcid_q;
  logic [7:0]             ovf_q;
  logic                   pop;
  logic                   accept;
  logic                   drop;

  // Synchronizer chain plus one extra flop for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], HitIn};
      s_dly_q <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_dly_q;

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; dropping Enable aborts whatever is in progress.
  always_comb begin
    state_d = state_q;
    if (!Enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (rise) state_d = ST_COUNT;
        ST_COUNT: begin
          if (!s)                     state_d = ST_IDLE;
          else if (cnt_q == MAX_TOT_C) state_d = ST_WAIT_LOW;
        end
        ST_WAIT_LOW: if (!s) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: counter/BCID capture and the emit strobe. The emitted ToT
  // is always cnt_q: on saturation cnt_q already equals MAX_TOT.
  always_comb begin
    cnt_d  = cnt_q;
    bcid_d = bcid_q;
    emit   = 1'b0;
    if (Enable) begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            cnt_d  = ONE_C;
            bcid_d = BcidIn;
          end
        end
        ST_COUNT: begin
          if (s && (cnt_q < MAX_TOT_C)) cnt_d = cnt_q + ONE_C;
          else                          emit  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ToT counter and leading-edge BCID holding registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q  <= '0;
      bcid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      bcid_q <= bcid_d;
    end
  end

  assign pop    = valid_q & rec_if.HitReady;
  assign accept = emit & (~valid_q | pop);
  assign drop   = emit & valid_q & ~rec_if.HitReady;

  // Output register: load on accept, clear valid on a pop without reload.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q    <= 1'b0;
      tot_q      <= '0;
      rec_bcid_q <= '0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      tot_q      <= cnt_q;
      rec_bcid_q <= bcid_q;
    end else if (pop) begin
      valid_q    <= 1'b0;
    end
  end

  // Saturating drop counter; a clear wins over a simultaneous drop.
  always_ff @(posedge Clk) begin
    if (Reset)                         ovf_q <= '0;
    else if (ClearOvf)                 ovf_q <= '0;
    else if (drop && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'd1;
  end

  assign rec_if.HitValid = valid_q;
  assign rec_if.HitTot   = tot_q;
  assign rec_if.HitBcid  = rec_bcid_q;
  assign OvfCnt          = ovf_q;
  assign Busy            = (state_q != ST_IDLE);
  assign dbg_state_o     = state_q;

endmodule

// File: doc/bgpv_tot_counter.md
Name: bgpv_tot_counter

Overview:
- Per-pixel hit digitizer directly downstream of the BGPV front-end control block.
- Takes the asynchronous, gated hit (HitOut of the FE control stage) and synchronizes it to the 40 MHz bunch-crossing clock.
- Measures time-over-threshold (ToT) in clock cycles and tags each hit with the BCID of its leading edge.
- Presents one record at a time to the pixel-region buffer over a valid/ready handshake; counts records dropped when that buffer stalls.

Parameters:
- TOT_WIDTH, 4, width of ToT field.
- MAX_TOT, 14, saturation value of ToT. Must be ≤ 2^TOT_WIDTH-2; code 15 is reserved by the region logic as "no hit".
- BCID_WIDTH, 8, width of BCID timestamp.
- SYNC_STAGES, 2, number of synchronizer flops on HitIn (≥2).

Ports:
- Clk  input  1  40 MHz bunch-crossing clock.
- Reset  input  1  synchronous, active-high reset.
- HitIn  input  1  asynchronous hit from FE control (HitOut), positive polarity.
- BcidIn  input  BCID_WIDTH  free-running BCID from the region.
- Enable  input  1  digitizer enable (region-level pixel enable).
- HitValid  output  1  record present in output register.
- HitTot  output  TOT_WIDTH  ToT of presented record.
- HitBcid  output  BCID_WIDTH  leading-edge BCID of presented record.
- HitReady  input  1  region buffer accepts record this cycle.
- Busy  output  1  FSM not in IDLE.
- OvfCnt  output  8  saturating count of dropped records.
- ClearOvf  input  1  synchronous clear of OvfCnt.

Behaviour:

Reset (synchronous, active-high):
- Sync chain, s_d, FSM=IDLE, cnt, HitValid, HitTot, HitBcid and OvfCnt all go to 0 on the first rising Clk edge with Reset=1.
- Reset mid-hit discards the hit and any pending record.

Synchronizer and edge detect:
- s = last sync flop; s_d = s delayed one cycle.
- rise = s & ~s_d. No other filtering.

FSM states:
- IDLE: on Enable & rise, set bcid_r<=BcidIn (value in the rise cycle), cnt<=1, go to COUNT.
- COUNT:
  - If s & cnt<MAX_TOT: cnt<=cnt+1.
  - If s & cnt==MAX_TOT: emit (MAX_TOT, bcid_r), go to WAIT_LOW.
  - If ~s: emit (cnt, bcid_r), go to IDLE.
- WAIT_LOW: stay until ~s, then go to IDLE. No emission; a rise cannot occur in this state.
- Enable=0 in any state: next state IDLE, no emission. Any hit in progress is aborted.

ToT rule:
- A sync-level pulse of N cycles yields ToT=min(N, MAX_TOT).
- Falling edge followed by a rise on the next cycle: the new rise is seen in IDLE and starts a new hit; no hit is lost.

Emission and output register:
- The record is written into the output register on the clock edge that ends the emitting cycle, so HitValid is high on the following cycle.
- Pop occurs when HitValid & HitReady.
- A write is accepted if ~HitValid or pop. Pop and write in the same cycle: the new record is loaded and HitValid stays 1.
- Pop with no write: HitValid<=0; HitTot and HitBcid hold their values.
- Write while HitValid & ~HitReady: the record is dropped, the held record is unchanged, and OvfCnt increments, saturating at 255.
- ClearOvf has priority over a simultaneous drop: OvfCnt<=0.

Other rules:
- Busy = (state!=IDLE), registered from state.
- Latency HitIn rise → sampled BCID: SYNC_STAGES cycles. The region compensates; this block applies no correction.
- BCID is not arithmetically modified. Wrap of BcidIn is passed through.

Test Plan:
- Reset, then HitIn high for 5 cycles with BcidIn=0x20 at rise detection → one record Tot=5, Bcid=0x20, HitValid high one cycle after the falling-edge cycle.
- HitIn high 40 cycles → record Tot=14 emitted at the 14th high cycle + 1, Busy stays 1 until s falls, no second record.
- Single-cycle HitIn pulse aligned to Clk → Tot=1. Two 3-cycle pulses separated by 1 low cycle → two records Tot=3, BCIDs 4 apart.
- HitReady=0, three hits of Tot 2,3,4 → first record (Tot=2) held, OvfCnt=2. Then HitReady=1 → record pops, OvfCnt stays 2. ClearOvf during a drop → OvfCnt=0.
- HitValid=1 with HitReady=1 in the same cycle a new hit falls → new record loaded, HitValid never drops, OvfCnt unchanged.
- Reset or Enable=0 asserted in COUNT after 3 cycles → no record, state IDLE. After Enable returns with HitIn still high, no record until a new rise.
